// File: rtl/bram_stream_reader.sv
// Burst read initiator: issues credit-limited BRAM reads, buffers returns, streams them out with tlast.
// Optional BRAM_STREAM_READER_STRIDE_EN adds a per-burst address stride input (default stride 1).
module bram_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
`ifdef BRAM_STREAM_READER_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  rden,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] dout,
    input  logic                  dack,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0]       DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

    if (FIFO_DEPTH < RD_LATENCY + 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("bram_stream_reader: FIFO_DEPTH must be a power of 2 and >= RD_LATENCY+2");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [ADDR_WIDTH-1:0]   addr_step;
    logic [LEN_WIDTH-1:0]    len_reg;
    logic [LEN_WIDTH-1:0]    issue_left_reg;
    logic [LEN_WIDTH-1:0]    deliv_reg;
    logic [CNT_W-1:0]        outstanding_reg;
    logic [CNT_W-1:0]        fifo_count_reg;
    logic [PTR_W-1:0]        wr_ptr_reg;
    logic [PTR_W-1:0]        rd_ptr_reg;
    logic                    done_reg;
    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];

    logic [CNT_W:0]          in_flight;
    logic                    credit;
    logic                    push;
    logic                    pop;

    // Credit covers both buffered words and reads still in flight, so the FIFO never overflows.
    assign in_flight = {1'b0, fifo_count_reg} + {1'b0, outstanding_reg};
    assign credit    = in_flight < DEPTH_C;
    assign rden      = (state_reg == S_ISSUE) && credit;
    assign push      = dack && (outstanding_reg != '0);
    assign pop       = m_tvalid && m_tready;

    assign m_tvalid  = (fifo_count_reg != '0);
    assign m_tdata   = m_tvalid ? fifo_mem[rd_ptr_reg] : '0;
    assign m_tlast   = m_tvalid && (deliv_reg == len_reg - LEN_ONE);
    assign busy      = (state_reg != S_IDLE);
    assign done      = done_reg;
    assign addr      = addr_reg;

`ifdef BRAM_STREAM_READER_STRIDE_EN
    logic [ADDR_WIDTH-1:0] step_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_reg <= '0;
        end else if (state_reg == S_IDLE && start) begin
            step_reg <= stride;
        end
    end

    assign addr_step = step_reg;
`else
    assign addr_step = ADDR_WIDTH'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            len_reg        <= '0;
            issue_left_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            addr_reg       <= base_addr;
                            len_reg        <= length;
                            issue_left_reg <= length;
                            state_reg      <= S_ISSUE;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (rden) begin
                        addr_reg       <= addr_reg + addr_step;
                        issue_left_reg <= issue_left_reg - LEN_ONE;
                        if (issue_left_reg == LEN_ONE) begin
                            state_reg <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop && m_tlast) begin
                        state_reg <= S_IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Datapath counters; a dack with nothing outstanding (e.g. after reset) never reaches the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_reg <= '0;
            fifo_count_reg  <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            deliv_reg       <= '0;
        end else begin
            case ({rden, push})
                2'b10:   outstanding_reg <= outstanding_reg + CNT_ONE;
                2'b01:   outstanding_reg <= outstanding_reg - CNT_ONE;
                default: outstanding_reg <= outstanding_reg;
            endcase
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + CNT_ONE;
                2'b01:   fifo_count_reg <= fifo_count_reg - CNT_ONE;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
                deliv_reg  <= deliv_reg + LEN_ONE;
            end
            if (state_reg == S_IDLE && start) begin
                deliv_reg <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= dout;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: bursts, wrap, back-pressure, zero length, reset mid-burst.
`timescale 1ns/1ps
module tb_bram_stream_reader;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic [AW-1:0] stride;
    logic          busy, done, rden;
    logic [AW-1:0] addr;
    logic [DW-1:0] dout;
    logic          dack;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tready, m_tlast;

    logic          dack_q = 1'b0;
    logic          dack_inj;
    logic [DW-1:0] dout_q = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t0 = 0;
    int s_rel;

    logic [AW-1:0] rd_addr_q[$];
    int            rd_rel_q[$];
    logic [DW-1:0] hs_data_q[$];
    logic          hs_last_q[$];
    int            hs_rel_q[$];
    int            done_cnt, done_rel, stall_viol;
    logic          busy_at_done, busy_seen;
    logic          stalled_prev;
    logic [DW-1:0] data_prev;
    logic          last_prev;

    bram_stream_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .RD_LATENCY(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
`ifdef BRAM_STREAM_READER_STRIDE_EN
        .stride(stride),
`endif
        .busy(busy), .done(done), .rden(rden), .addr(addr), .dout(dout), .dack(dack),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return DW'(a);
    endfunction

    // One-cycle-latency BRAM model; dack_inj forces a stray acknowledge.
    always @(posedge clk) begin
        dack_q <= rden;
        dout_q <= mem_word(addr);
        cyc    <= cyc + 1;
    end
    assign dack = dack_q | dack_inj;
    assign dout = dout_q;

    always @(negedge clk) begin
        s_rel = cyc - t0;
        if (!rst) begin
            if (rden) begin
                rd_addr_q.push_back(addr);
                rd_rel_q.push_back(s_rel);
            end
            if (m_tvalid && m_tready) begin
                hs_data_q.push_back(m_tdata);
                hs_last_q.push_back(m_tlast);
                hs_rel_q.push_back(s_rel);
            end
            if (done) begin
                done_cnt++;
                done_rel     = s_rel;
                busy_at_done = busy;
            end
            if (busy) busy_seen = 1'b1;
            if (stalled_prev && (!m_tvalid || m_tdata != data_prev || m_tlast != last_prev))
                stall_viol++;
            stalled_prev = m_tvalid && !m_tready;
            data_prev    = m_tdata;
            last_prev    = m_tlast;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rd_addr_q.delete(); rd_rel_q.delete();
        hs_data_q.delete(); hs_last_q.delete(); hs_rel_q.delete();
        done_cnt = 0; done_rel = -1; stall_viol = 0;
        busy_at_done = 1'b1; busy_seen = 1'b0; stalled_prev = 1'b0;
    endtask

    task automatic launch(input logic [AW-1:0] base, input logic [LW-1:0] len);
        clear_log();
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; length = len;
        @(posedge clk); #1;
        start = 1'b0; t0 = cyc;
    endtask

    // Runs one burst; m_tready is low for relative cycles st_lo..st_hi (rel 0 = first rden cycle).
    task automatic run_burst(input logic [AW-1:0] base, input logic [LW-1:0] len,
                             input int st_lo, input int st_hi, input bit ghost);
        bit got;
        got = 1'b0;
        launch(base, len);
        for (int rel = 0; rel < 400; rel++) begin
            m_tready = !(rel >= st_lo && rel <= st_hi);
            if (ghost) begin
                start = (rel == 5); base_addr = 8'h80; length = 8'd3;
            end
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; m_tready = 1'b1;
        check("done_seen", 32'(got), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_stream(input logic [AW-1:0] base, input int len);
        logic [AW-1:0] a;
        a = base;
        check("rd_count", 32'(rd_addr_q.size()), 32'(len));
        check("hs_count", 32'(hs_data_q.size()), 32'(len));
        for (int i = 0; i < len && i < hs_data_q.size() && i < rd_addr_q.size(); i++) begin
            check("rd_addr", 32'(rd_addr_q[i]), 32'(a));
            check("data", 32'(hs_data_q[i]), 32'(mem_word(a)));
            check("last", 32'(hs_last_q[i]), 32'(i == len - 1));
            a = a + stride;
        end
        check("done_cnt", 32'(done_cnt), 32'd1);
        check("busy_at_done", 32'(busy_at_done), 32'd0);
        check("stall_hold", 32'(stall_viol), 32'd0);
        $display("burst base=0x%02h len=%0d words=%0d done_rel=%0d",
                 base, len, hs_data_q.size(), done_rel);
    endtask

    initial begin
        int early;
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        m_tready = 1'b1; dack_inj = 1'b0; stride = 8'd1;
        clear_log();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rden", 32'(rden), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic burst with exact latency checks.
        run_burst(8'h10, 8'd4, 1000, 0, 1'b0);
        check_stream(8'h10, 4);
        if (rd_rel_q.size() >= 1) check("first_rden_rel", 32'(rd_rel_q[0]), 32'd0);
        if (hs_rel_q.size() >= 4) begin
            check("first_hs_rel", 32'(hs_rel_q[0]), 32'd2);
            check("last_hs_rel", 32'(hs_rel_q[3]), 32'd5);
        end
        check("done_rel", 32'(done_rel), 32'd6);

        // Address wrap past the top.
        run_burst(8'hFE, 8'd4, 1000, 0, 1'b0);
        check_stream(8'hFE, 4);

        // Back-pressure with an ignored start while busy.
        run_burst(8'h40, 8'd8, 2, 9, 1'b1);
        check_stream(8'h40, 8);
        early = 0;
        foreach (rd_rel_q[i]) if (rd_rel_q[i] <= 9) early++;
        check("bp_rden_credit", 32'(early), 32'd4);
        if (hs_rel_q.size() >= 1) check("bp_first_hs_rel", 32'(hs_rel_q[0]), 32'd10);
        check("bp_done_rel", 32'(done_rel), 32'd18);

        // Zero length.
        run_burst(8'h55, 8'd0, 1000, 0, 1'b0);
        check("zl_rden", 32'(rd_addr_q.size()), 32'd0);
        check("zl_done_rel", 32'(done_rel), 32'd0);
        check("zl_done_cnt", 32'(done_cnt), 32'd1);
        check("zl_busy", 32'(busy_seen), 32'd0);
        $display("burst base=0x55 len=0 words=%0d done_rel=%0d", hs_data_q.size(), done_rel);

        // Reset after two of six words.
        launch(8'h20, 8'd6);
        for (int i = 0; i < 50 && hs_data_q.size() < 2; i++) @(negedge clk);
        check("mid_hs_count", 32'(hs_data_q.size()), 32'd2);
        if (hs_data_q.size() >= 2) check("mid_word1", 32'(hs_data_q[1]), 32'h21);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_rden", 32'(rden), 32'd0);
        check("mrst_addr", 32'(addr), 32'd0);
        check("mrst_tvalid", 32'(m_tvalid), 32'd0);
        check("mrst_tlast", 32'(m_tlast), 32'd0);
        check("mrst_tdata", 32'(m_tdata), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; dack_inj = 1'b1;
        @(negedge clk);
        check("late_dack_v0", 32'(m_tvalid), 32'd0);
        @(posedge clk); #1;
        dack_inj = 1'b0;
        @(negedge clk);
        check("late_dack_v1", 32'(m_tvalid), 32'd0);
        $display("burst base=0x20 len=6 reset after %0d words", hs_data_q.size());
        run_burst(8'h30, 8'd2, 1000, 0, 1'b0);
        check_stream(8'h30, 2);

`ifdef BRAM_STREAM_READER_STRIDE_EN
        stride = 8'd3;
        run_burst(8'h01, 8'd3, 1000, 0, 1'b0);
        check_stream(8'h01, 3);
        stride = 8'd1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side initiator for a BRAM port with read-enable/acknowledge: on a start command it issues a burst of reads from a base address, collects the returned words by their `dack` strobe, and emits them on a valid/ready stream with `tlast` on the final word. It drives one port of the multi-port BRAM wrapper (`rden`/`addr` out, `dout`/`dack` in) and feeds a downstream stream consumer. It is credit-based, so it never drops data under stream back-pressure.

## Interface
- `DATA_WIDTH`, 16: BRAM word and stream data width.
- `ADDR_WIDTH`, 8: BRAM port address width.
- `LEN_WIDTH`, 8: burst length field width (words).
- `RD_LATENCY`, 1: BRAM cycles from `rden` to `dack`.
- `FIFO_DEPTH`, 4: return buffer depth. Power of 2. Must be ≥ `RD_LATENCY`+2.

Ports:
- `clk` input 1: single clock. All logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: command strobe, sampled only in IDLE.
- `base_addr` input ADDR_WIDTH: first read address, sampled with `start`.
- `length` input LEN_WIDTH: number of words, sampled with `start`. 0 is a no-op.
- `busy` output 1: high while not IDLE.
- `done` output 1: one-cycle pulse when the burst completes.
- `rden` output 1: BRAM read enable.
- `addr` output ADDR_WIDTH: BRAM read address.
- `dout` input DATA_WIDTH: BRAM read data, valid when `dack`=1.
- `dack` input 1: BRAM read-data acknowledge.
- `m_tdata` output DATA_WIDTH: stream data.
- `m_tvalid` output 1: stream valid.
- `m_tready` input 1: stream ready.
- `m_tlast` output 1: marks the final word of the burst.

## Operation
- The FSM has three states: IDLE, ISSUE and DRAIN.
- **IDLE**
  - `start` with `length`≠0: latch `base_addr` and `length`, then go to ISSUE.
  - `start` with `length`=0: pulse `done` on the next cycle and stay in IDLE.
- **ISSUE**
  - `rden`=1 whenever credit is available. Credit means `fifo_count` + `outstanding` < `FIFO_DEPTH`.
  - Each issued read increments `addr`, modulo 2^ADDR_WIDTH, so a burst may wrap past the top address to 0.
  - Go to DRAIN in the cycle after the `length`-th read is issued.
- **DRAIN**
  - Issue no reads.
  - Wait for the handshake `m_tvalid`&`m_tready`&`m_tlast`. Then return to IDLE with a `done` pulse in the following cycle.
- **Outstanding counter**
  - +1 on each `rden`, −1 on each `dack`. Both in one cycle leave it unchanged.
  - A `dack` while `outstanding`=0 is ignored and writes nothing to the FIFO.
- **Return FIFO**
  - Each accepted `dack` writes `dout` into the FIFO.
  - `m_tdata`/`m_tvalid` come from the FIFO head.
  - A simultaneous push and pop keeps the count unchanged. The FIFO cannot overflow because of the credit rule.
- **`m_tlast`** is high only on the word whose stream index equals `length`−1. A delivered-word counter tracks this.
- **Outputs while `m_tvalid`=1 and `m_tready`=0:** `m_tdata`, `m_tvalid` and `m_tlast` hold stable. They do not depend combinationally on `m_tready`.
- **`start` while `busy`** is ignored.
- **`rst` mid-burst:** state returns to IDLE and the FIFO, counters and outstanding count are cleared. Late `dack`s are ignored by the outstanding rule.

## Timing
- **Reset values:** `busy`=0, `done`=0, `rden`=0, `addr`=0, `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0.
- **Start-to-read:** `start` sampled at edge k; the first `rden` with `addr`=`base_addr` is in cycle k+1.
- **Read-to-stream, `RD_LATENCY`=1:**
  - `dack` is in cycle k+2.
  - The word is written at edge k+2.
  - `m_tvalid` rises in cycle k+3.
- **Throughput:** with `m_tready` held high and `FIFO_DEPTH` ≥ `RD_LATENCY`+2, one word per cycle. An N-word burst has its last handshake in cycle k+N+2.
- **Done:** `done` is high in the cycle after the `tlast` handshake. `busy` falls in that same cycle.
- **`rden`** is combinational from state and credit. `addr` is registered.

## Configuration
- `BRAM_STREAM_READER_STRIDE_EN`
  - **Defined:** adds input `stride` [ADDR_WIDTH], sampled with `start`. The address advances by `stride` per read, modulo 2^ADDR_WIDTH. `stride`=0 rereads `base_addr` `length` times.
  - **Undefined:** the port is absent and the stride is fixed at 1.

## Test plan
- **Basic burst:** `base_addr`=0x10, `length`=4, memory[i]=i, `m_tready`=1 → `m_tdata` 0x10..0x13 on consecutive cycles k+3..k+6. `m_tlast` only on 0x13. `done` in cycle k+7.
- **Wrap:** `base_addr`=0xFE, `length`=4 → reads 0xFE, 0xFF, 0x00, 0x01, and the data arrives in that order.
- **Back-pressure:** `length`=8, `m_tready` low for cycles 3–10.
  - `rden` stops once `fifo_count` + `outstanding` = 4.
  - No word is lost or duplicated.
  - `m_tdata` holds stable while stalled.
- **Zero length:** `start` with `length`=0 → no `rden`, `done` pulse next cycle, `busy` stays 0.
- **Reset mid-burst:** assert `rst` after 2 of 6 words.
  - All outputs return to reset values.
  - A `dack` in the cycle after `rst` deasserts produces no `m_tvalid`.
  - A new `length`=2 burst then completes correctly.
- **Stride (macro defined):** `stride`=3, `base_addr`=1, `length`=3 → addresses 1, 4, 7.
